// File: rtl/multi_channel_duration_timer.sv
// Bank of independent note-duration countdown timers sharing one beat tick.
// Each channel counts a loaded beat count down to a done pulse, optionally delayed and auto-reloaded.
module multi_channel_duration_timer #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 6,
  parameter int DONE_DELAY = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      playing,
  input  logic                      beat,
  input  logic [CHANNELS-1:0]       load_new,
  input  logic [CHANNELS*WIDTH-1:0] duration,
  input  logic [CHANNELS-1:0]       auto_reload,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       busy,
  output logic                      any_done
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COUNTING = 2'd1,
    S_DONE     = 2'd2
  } state_t;

  state_t           state_q  [CHANNELS];
  state_t           state_d  [CHANNELS];
  logic [WIDTH-1:0] count_q  [CHANNELS];
  logic [WIDTH-1:0] count_d  [CHANNELS];
  logic [WIDTH-1:0] reload_q [CHANNELS];
  logic [WIDTH-1:0] reload_d [CHANNELS];

  logic [CHANNELS-1:0] fire_p0;
  logic [CHANNELS-1:0] fire_out;

  // Saturating decrement: the count floors at zero instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    sat_dec = (v == '0) ? '0 : v - 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= S_IDLE;
        count_q[i]  <= '0;
        reload_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        reload_q[i] <= reload_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      reload_d[i] = reload_q[i];
      if (playing) begin
        if (load_new[i]) begin
          // A load overrides beat and auto-reload; a zero duration expires on the next cycle.
          count_d[i]  = duration[i*WIDTH +: WIDTH];
          reload_d[i] = duration[i*WIDTH +: WIDTH];
          state_d[i]  = (duration[i*WIDTH +: WIDTH] != '0) ? S_COUNTING : S_DONE;
        end else begin
          case (state_q[i])
            S_COUNTING: begin
              if (beat) begin
                count_d[i] = sat_dec(count_q[i]);
                if (count_q[i] <= WIDTH'(1)) state_d[i] = S_DONE;
              end
            end
            S_DONE: begin
              if (auto_reload[i] && (reload_q[i] != '0)) begin
                count_d[i] = reload_q[i];
                state_d[i] = S_COUNTING;
              end else begin
                state_d[i] = S_IDLE;
              end
            end
            default: state_d[i] = S_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      busy[i]    = (state_q[i] == S_COUNTING);
      fire_p0[i] = (state_q[i] == S_DONE);
    end
  end

  // fire_p0 -> optional playing-gated delay stages -> fire_out
  generate
    if (DONE_DELAY == 0) begin : g_no_delay
      assign fire_out = fire_p0;
    end else begin : g_delay
      logic [CHANNELS-1:0] fire_dly [DONE_DELAY];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < DONE_DELAY; k++) fire_dly[k] <= '0;
        end else if (playing) begin
          fire_dly[0] <= fire_p0;
          for (int k = 1; k < DONE_DELAY; k++) fire_dly[k] <= fire_dly[k-1];
        end
      end

      assign fire_out = fire_dly[DONE_DELAY-1];
    end
  endgenerate

  assign done     = {CHANNELS{playing}} & fire_out;
  assign any_done = |done;

endmodule
